mem_responder: RTL and testbench

Multi-cycle memory target answering the load/store requests issued by the MIPS_32 datapath. It replaces the zero-latency data memory with a valid/ready request channel, a configurable wait-state counter and a held response channel. It supports byte, halfword and word accesses with sign or zero extension, so the CPU side can be exercised against realistic memory latency.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/mem_lane_align.sv | 73 +++++++
 rtl/mem_responder.sv | 174 +++++++++++++++++
 tb/tb_mem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the mem_responder slice: access-size encodings,
// FSM state constants, byte-lane mask constants and load-extension helpers.
// Ports: none (package).
// -----------------------------------------------------------------------------
package mem_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;   // illegal

    // FSM state encoding
    typedef logic [1:0] mem_state_t;
    localparam mem_state_t ST_IDLE   = 2'd0;
    localparam mem_state_t ST_WAIT   = 2'd1;
    localparam mem_state_t ST_ACCESS = 2'd2;
    localparam mem_state_t ST_RESP   = 2'd3;

    // Byte-lane masks for lane 0; shifted left by the (aligned) lane offset
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Extend a byte to 32 bits, sign or zero depending on sgn
    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        ext_byte = {{24{sgn & b[7]}}, b};
    endfunction

    // Extend a halfword to 32 bits, sign or zero depending on sgn
    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        ext_half = {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational little-endian byte-lane steering for one memory word.
// Ports:
//   size      - access size (SIZE_B/H/W; anything else yields no lanes)
//   addr_lo   - byte offset in the word, already aligned to the access size
//   signed_ld - load extension: 1 sign, 0 zero
//   raw_word  - current contents of the addressed word
//   wdata     - right-aligned store data
//   wmask     - byte-write mask (bit i = byte lane i)
//   wmerged   - raw_word with the masked lanes replaced by store data
//   rdata_ext - extracted and extended load value
// -----------------------------------------------------------------------------
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        signed_ld,
    input  logic [31:0] raw_word,
    input  logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic [31:0] wmerged,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted_s;
    logic [31:0] wrep_s;

    // Lane mask, store-data replication and load extraction per access size
    always_comb begin
        wmask     = 4'b0000;
        wrep_s    = 32'h0000_0000;
        rdata_ext = 32'h0000_0000;
        // Bring the addressed lane down to bit 0 for extraction
        shifted_s = raw_word >> {addr_lo, 3'b000};
        case (size)
            SIZE_B: begin
                wmask     = MASK_B << addr_lo;
                wrep_s    = {4{wdata[7:0]}};
                rdata_ext = ext_byte(shifted_s[7:0], signed_ld);
            end
            SIZE_H: begin
                wmask     = MASK_H << addr_lo;
                wrep_s    = {2{wdata[15:0]}};
                rdata_ext = ext_half(shifted_s[15:0], signed_ld);
            end
            SIZE_W: begin
                wmask     = MASK_W;
                wrep_s    = wdata;
                rdata_ext = raw_word;
            end
            default: begin
                wmask     = 4'b0000;
                wrep_s    = 32'h0000_0000;
                rdata_ext = 32'h0000_0000;
            end
        endcase
    end

    // Per-lane merge so unaddressed bytes keep their old value
    always_comb begin
        wmerged = raw_word;
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) begin
                wmerged[8*i +: 8] = wrep_s[8*i +: 8];
            end else begin
                wmerged[8*i +: 8] = raw_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Multi-cycle memory target with a valid/ready request channel, a wait-state
// counter and a response channel held stable until consumed. Supports byte,
// halfword and word loads/stores with sign or zero extension on loads.
//
// Build option: define MEM_RESPONDER_ALIGN_CHECK_EN to flag misaligned
// halfword/word accesses as errors; otherwise low address bits below the
// access size are dropped and the access proceeds aligned.
//
// Parameters: DEPTH_WORDS (words stored), WAIT_CYCLES (extra latency, >= 0)
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_ready   - request handshake (ready only in IDLE)
//   req_we, req_addr, req_size, req_signed, req_wdata - request fields
//   rsp_valid/rsp_ready   - response handshake
//   rsp_rdata, rsp_err    - load data (0 for stores/errors), fault flag
// -----------------------------------------------------------------------------
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);

    mem_state_t        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              we_r;
    logic [31:0]       addr_r;
    logic [1:0]        size_r;
    logic              signed_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rsp_rdata_r;
    logic              rsp_err_r;

    logic [31:0]       mem_r [DEPTH_WORDS];

    logic              size_bad_s;
    logic              range_bad_s;
    logic              err_s;
    logic [1:0]        addr_lo_s;
    logic [IDX_W-1:0]  idx_s;
    logic [31:0]       raw_word_s;
    logic [3:0]        wmask_s;
    logic [31:0]       wmerged_s;
    logic [31:0]       rdata_ext_s;
    logic              mem_wr_s;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    logic              misalign_s;
`endif

    assign req_ready = (state_r == ST_IDLE);
    assign rsp_valid = (state_r == ST_RESP);
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    assign idx_s      = addr_r[IDX_W+1:2];
    assign raw_word_s = mem_r[idx_s];

    // Fault detection and lane alignment for the latched request
    always_comb begin
        size_bad_s  = (size_r == SIZE_X);
        range_bad_s = ({2'b00, addr_r[31:2]} >= DEPTH_W32);
        // Drop offset bits below the access size
        case (size_r)
            SIZE_H:  addr_lo_s = {addr_r[1], 1'b0};
            SIZE_W:  addr_lo_s = 2'b00;
            default: addr_lo_s = addr_r[1:0];
        endcase
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        misalign_s = ((size_r == SIZE_H) && addr_r[0]) ||
                     ((size_r == SIZE_W) && (addr_r[1:0] != 2'b00));
        err_s      = size_bad_s | range_bad_s | misalign_s;
`else
        err_s      = size_bad_s | range_bad_s;
`endif
        mem_wr_s = (state_r == ST_ACCESS) && we_r && !err_s && (wmask_s != 4'b0000);
    end

    mem_lane_align u_align (
        .size      (size_r),
        .addr_lo   (addr_lo_s),
        .signed_ld (signed_r),
        .raw_word  (raw_word_s),
        .wdata     (wdata_r),
        .wmask     (wmask_s),
        .wmerged   (wmerged_s),
        .rdata_ext (rdata_ext_s)
    );

    // Control FSM, request capture and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            we_r        <= 1'b0;
            addr_r      <= 32'h0000_0000;
            size_r      <= 2'b00;
            signed_r    <= 1'b0;
            wdata_r     <= 32'h0000_0000;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_r     <= req_we;
                        addr_r   <= req_addr;
                        size_r   <= req_size;
                        signed_r <= req_signed;
                        wdata_r  <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_r <= ST_ACCESS;
                        end else begin
                            cnt_r   <= CNT_W'(WAIT_CYCLES - 1);
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == '0) begin
                        state_r <= ST_ACCESS;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                ST_ACCESS: begin
                    rsp_err_r <= err_s;
                    if (err_s || we_r) begin
                        rsp_rdata_r <= 32'h0000_0000;
                    end else begin
                        rsp_rdata_r <= rdata_ext_s;
                    end
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage array: no reset, written only in a fault-free store ACCESS cycle
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            mem_r[idx_s] <= wmerged_s;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder: a driver issues requests and pushes the
// hand-computed response into a queue; a monitor pops and compares whenever a
// response handshake is seen. Latency, stall hold and reset drop are checked
// inline by the driver.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int DEPTH = 256;
    localparam int WAITC = 2;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          id;
    } exp_t;
    exp_t exp_q[$];

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every response handshake is compared against the queue head
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got %h/%b, expected no response", rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("rsp%0d_data", e.id), rsp_rdata, e.d);
                check($sformatf("rsp%0d_err", e.id), {31'b0, rsp_err}, {31'b0, e.e});
            end
        end
    end

    // Issue one request, check acceptance-to-valid latency, optionally wait for IDLE
    task automatic issue(input int id, input logic we, input logic [31:0] addr,
                         input logic [1:0] sz, input logic sg, input logic [31:0] wd,
                         input logic [31:0] ed, input logic ee, input bit wait_done);
        int cyc;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_size = sz; req_signed = sg; req_wdata = wd;
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept%0d: req_ready got 0, expected 1", id);
            req_valid = 1'b0;
            return;
        end
        e.d = ed; e.e = ee; e.id = id;
        exp_q.push_back(e);
        @(posedge clk);   // acceptance edge = cycle 0
        #1;
        req_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check($sformatf("lat%0d", id), 32'(cyc), 32'(WAITC + 1));
        if (wait_done) begin
            cyc = 0;
            while (!req_ready && cyc < 50) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check($sformatf("idle%0d", id), {31'b0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [31:0] w12;
        int cyc;
        w12 = ALIGN ? 32'h0000_8000 : 32'hCAFE_8000;

        // Reset state
        #12;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store/load, then byte lanes with extension
        issue(1,  1'b1, 32'h10,  2'b10, 1'b0, 32'hDEADBEEF, 32'h0,         1'b0, 1'b1);
        issue(2,  1'b0, 32'h10,  2'b10, 1'b0, 32'h0,        32'hDEADBEEF,  1'b0, 1'b1);
        issue(3,  1'b1, 32'h10,  2'b10, 1'b0, 32'h0,        32'h0,         1'b0, 1'b1);
        issue(4,  1'b1, 32'h11,  2'b00, 1'b0, 32'h80,       32'h0,         1'b0, 1'b1);
        issue(5,  1'b0, 32'h11,  2'b00, 1'b1, 32'h0,        32'hFFFFFF80,  1'b0, 1'b1);
        issue(6,  1'b0, 32'h11,  2'b00, 1'b0, 32'h0,        32'h00000080,  1'b0, 1'b1);
        issue(7,  1'b0, 32'h10,  2'b10, 1'b0, 32'h0,        32'h00008000,  1'b0, 1'b1);

        // Out-of-range and illegal size; out-of-range store must not alias word 0
        issue(8,  1'b1, 32'h0,   2'b10, 1'b0, 32'hA5A5A5A5, 32'h0,         1'b0, 1'b1);
        issue(9,  1'b0, 32'h400, 2'b10, 1'b0, 32'h0,        32'h0,         1'b1, 1'b1);
        issue(10, 1'b1, 32'h400, 2'b10, 1'b0, 32'h11111111, 32'h0,         1'b1, 1'b1);
        issue(11, 1'b0, 32'h0,   2'b10, 1'b0, 32'h0,        32'hA5A5A5A5,  1'b0, 1'b1);
        issue(12, 1'b0, 32'h10,  2'b11, 1'b0, 32'h0,        32'h0,         1'b1, 1'b1);

        // Halfword loads and the misaligned halfword store
        issue(13, 1'b0, 32'h10,  2'b01, 1'b1, 32'h0,        32'hFFFF8000,  1'b0, 1'b1);
        issue(14, 1'b0, 32'h10,  2'b01, 1'b0, 32'h0,        32'h00008000,  1'b0, 1'b1);
        issue(15, 1'b1, 32'h13,  2'b01, 1'b0, 32'hCAFE,     32'h0,         ALIGN, 1'b1);
        issue(16, 1'b0, 32'h10,  2'b10, 1'b0, 32'h0,        w12,           1'b0, 1'b1);
        issue(17, 1'b0, 32'h12,  2'b01, 1'b1, 32'h0,
              ALIGN ? 32'h0 : 32'hFFFFCAFE, 1'b0, 1'b1);
        issue(18, 1'b0, 32'h11,  2'b10, 1'b0, 32'h0,
              ALIGN ? 32'h0 : w12, ALIGN, 1'b1);

        // Stall in RESP; a request offered meanwhile must be ignored
        rsp_ready = 1'b0;
        issue(19, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, w12, 1'b0, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0;
        req_size = 2'b10; req_wdata = 32'hFFFFFFFF;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_flags", k), {29'b0, rsp_valid, req_ready, rsp_err}, 32'd4);
            check($sformatf("stall%0d_data", k), rsp_rdata, w12);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("release_idle", {30'b0, req_ready, rsp_valid}, 32'd2);
        issue(20, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1);

        // Reset during WAIT of a store drops it
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
        req_size = 2'b10; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("midrst_flags", {30'b0, req_ready, rsp_valid}, 32'd2);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("postrst_flags", {30'b0, req_ready, rsp_valid}, 32'd2);
        check("postrst_rdata", rsp_rdata, 32'h0);
        issue(21, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, w12, 1'b0, 1'b1);

        // Drain scoreboard
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(posedge clk);
            cyc++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global bound on run time
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
